// File: rtl/lcd_text_buffer.sv
// Writable 2x16 character buffer for the LCD controller: a valid/ready write
// stream with terminal-style control codes, and a ROM-compatible combinational read port.
module lcd_text_buffer #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] lcd_index,
    output logic [7:0] lcd_char,
    output logic [4:0] cursor,
    output logic       busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic [4:0] cursor_q, cursor_d;
    logic       in_ready_q;
    logic       busy_q;
    logic [7:0] mem_q [32];

    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       xfer;
    logic       printable;

    assign xfer      = in_valid && in_ready_q;
    assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cursor_d  = cursor_q;
        we        = 1'b0;
        waddr     = clr_cnt_q;
        wdata     = CLEAR_CHAR;
        case (state_q)
            ST_CLEAR: begin
                we        = 1'b1;
                clr_cnt_d = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) begin
                    state_d  = ST_IDLE;
                    cursor_d = 5'd0;
                end
            end
            ST_IDLE: begin
                if (xfer) begin
                    if (printable) begin
                        we       = 1'b1;
                        waddr    = cursor_q;
                        wdata    = in_char;
                        cursor_d = cursor_q + 5'd1;
                    end else begin
                        case (in_char)
                            8'h0D: cursor_d = {cursor_q[4], 4'b0000};
                            8'h0A: cursor_d = {~cursor_q[4], 4'b0000};
                            8'h08: cursor_d = cursor_q - 5'd1;
                            8'h0C: begin
                                state_d   = ST_CLEAR;
                                clr_cnt_d = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Handshake flags follow the next state so in_ready never depends on in_valid.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= 5'd0;
            cursor_q   <= 5'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cursor_q   <= cursor_d;
            in_ready_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d == ST_CLEAR);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (we && !reset) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign lcd_char = mem_q[lcd_index];
    assign in_ready = in_ready_q;
    assign cursor   = cursor_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Bench for lcd_text_buffer: directed table of characters, multi-cycle clear and
// read-during-write sequences, and a random stream checked against a cycle model.
module tb_lcd_text_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] lcd_index;
    logic [7:0] lcd_char;
    logic [4:0] cursor;
    logic       busy;

    lcd_text_buffer dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .in_char  (in_char),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lcd_index(lcd_index),
        .lcd_char (lcd_char),
        .cursor   (cursor),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: screen contents, cursor, and how many clear cycles remain.
    logic [7:0] m_mem [32];
    bit         m_known [32];
    int         m_cur;
    int         m_clr_left;
    int         m_clr_pos;

    typedef struct {
        logic [7:0] ch;
        int         exp_cur;
        int         rd_idx;
        logic [7:0] rd_exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int c;
        c = int'(in_char);
        if (reset) begin
            m_clr_left = 32;
            m_clr_pos  = 0;
            m_cur      = 0;
        end else if (m_clr_left > 0) begin
            m_mem[m_clr_pos]   = 8'h20;
            m_known[m_clr_pos] = 1'b1;
            m_clr_pos++;
            m_clr_left--;
            if (m_clr_left == 0) m_cur = 0;
        end else if (in_valid) begin
            if (c >= 32 && c <= 126) begin
                m_mem[m_cur]   = in_char;
                m_known[m_cur] = 1'b1;
                m_cur          = (m_cur + 1) % 32;
            end else if (c == 13) m_cur = m_cur - (m_cur % 16);
            else if (c == 10) m_cur = (m_cur < 16) ? 16 : 0;
            else if (c == 8)  m_cur = (m_cur + 31) % 32;
            else if (c == 12) begin
                m_clr_left = 32;
                m_clr_pos  = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("in_ready", in_ready, (m_clr_left == 0));
        chk("busy", busy, (m_clr_left > 0));
        chk("cursor", cursor, m_cur);
        if (m_known[lcd_index]) chk("lcd_char", lcd_char, m_mem[lcd_index]);
    endtask

    task automatic send(input logic [7:0] c);
        in_char  = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            chk({name, "_busy"}, busy, 1'b1);
            step();
            n++;
        end
        chk({name, "_low_cycles"}, n, 32);
    endtask

    task automatic check_all_clear(input string name);
        for (int i = 0; i < 32; i++) begin
            lcd_index = 5'(i);
            #1;
            chk(name, lcd_char, 8'h20);
        end
    endtask

    function automatic void add(input logic [7:0] ch, input int cur, input int idx, input logic [7:0] rd);
        vec_t v;
        v.ch = ch; v.exp_cur = cur; v.rd_idx = idx; v.rd_exp = rd;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [7:0] hello [5];
        int r;

        add(8'h0D, 0, 0, 8'h48);
        for (int i = 0; i < 16; i++) add(8'h41, i + 1, i, 8'h41);
        add(8'h0D, 16, 15, 8'h41);
        add(8'h42, 17, 16, 8'h42);
        add(8'h0A, 0, 16, 8'h42);
        add(8'h43, 1, 0, 8'h43);
        add(8'h08, 0, 0, 8'h43);
        add(8'h08, 31, 31, 8'h20);
        add(8'h5A, 0, 31, 8'h5A);
        add(8'h08, 31, 31, 8'h5A);
        add(8'h0A, 0, 31, 8'h5A);
        add(8'h78, 1, 0, 8'h78);
        add(8'h79, 2, 1, 8'h79);
        add(8'h7A, 3, 2, 8'h7A);
        add(8'h07, 3, 3, 8'h41);
        add(8'hFF, 3, 3, 8'h41);
        add(8'h7F, 3, 3, 8'h41);
        add(8'h1F, 3, 3, 8'h41);

        for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
        m_cur = 0; m_clr_left = 32; m_clr_pos = 0;
        reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; lcd_index = 5'd0;

        // Reset, then the power-up clear.
        step();
        step();
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_busy", busy, 1'b1);
        chk("reset_cursor", cursor, 5'd0);
        reset = 1'b0;
        count_clear("init_clear");
        chk("init_cursor", cursor, 5'd0);
        check_all_clear("init_fill");

        // Back-to-back stream with in_valid held high.
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_char = hello[i];
            step();
            chk("stream_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        chk("hello_cursor", cursor, 5'd5);
        for (int i = 0; i < 5; i++) begin
            lcd_index = 5'(i);
            #1;
            chk("hello_mem", lcd_char, hello[i]);
        end

        foreach (vecs[k]) begin
            send(vecs[k].ch);
            lcd_index = 5'(vecs[k].rd_idx);
            #1;
            chk("vec_cursor", cursor, vecs[k].exp_cur);
            chk("vec_read", lcd_char, vecs[k].rd_exp);
            $display("vec %0d: ch=%02h cursor=%0d mem[%0d]=%02h", k, vecs[k].ch, cursor, lcd_index, lcd_char);
        end

        // Read-during-write at cursor 3: old value this cycle, new value next.
        lcd_index = 5'd3;
        in_char   = 8'h51;
        in_valid  = 1'b1;
        #1;
        chk("rdw_old", lcd_char, 8'h41);
        step();
        in_valid = 1'b0;
        chk("rdw_new", lcd_char, 8'h51);
        chk("rdw_cursor", cursor, 5'd4);

        // Form feed clear.
        send(8'h0C);
        chk("ff_ready_drop", in_ready, 1'b0);
        count_clear("ff_clear");
        chk("ff_cursor", cursor, 5'd0);
        check_all_clear("ff_fill");

        // Reset in the middle of a clear restarts it.
        send(8'h41);
        send(8'h0C);
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_clear("rst_mid_clear");
        chk("rst_mid_cursor", cursor, 5'd0);
        check_all_clear("rst_mid_fill");

        // Random stream against the model.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            lcd_index = 5'($urandom_range(0, 31));
            r = $urandom_range(0, 19);
            if (r < 12)       in_char = 8'($urandom_range(32, 126));
            else if (r == 12) in_char = 8'h0D;
            else if (r == 13) in_char = 8'h0A;
            else if (r == 14) in_char = 8'h08;
            else if (r == 15) in_char = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h07;
            else              in_char = 8'($urandom_range(0, 255));
            step();
        end
        reset = 1'b0;
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Writable 32-character display buffer that replaces the fixed message ROM upstream of LCD_Controller.
- Read side has the same interface as the ROM: a 5-bit lcd_index in, an 8-bit lcd_char out.
- Write side accepts a valid/ready character stream and interprets printable ASCII and a small set of control codes, terminal-style.
- Layout is 2 lines x 16 characters: addresses 0-15 are line 0, addresses 16-31 are line 1.

Parameters:
- CLEAR_CHAR, 8'h20, fill value written on reset and on form feed.

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_char  input  8  incoming character code.
- in_valid  input  1  in_char is valid this cycle.
- in_ready  output  1  buffer can accept a character this cycle.
- lcd_index  input  5  read address, driven by LCD_Controller.
- lcd_char  output  8  character at lcd_index; combinational read.
- cursor  output  5  next write address.
- busy  output  1  high while a clear sequence runs.

Behaviour:
- Storage: 32 x 8 register array.
  - Read is combinational: lcd_char = mem[lcd_index].
  - Writes are registered.
  - Reading and writing the same address in one cycle returns the old value in that cycle and the new value from the next cycle.
- A transfer occurs on a rising edge where in_valid && in_ready are both high. in_char is sampled only on a transfer.
- FSM has two states, CLEAR and IDLE.
  - Reset: state=CLEAR, clr_cnt=0, cursor=0, in_ready=0, busy=1.
  - Reset is honoured in any state, including mid-clear; the clear restarts from address 0.
- CLEAR state:
  - Each cycle: mem[clr_cnt] <= CLEAR_CHAR, then clr_cnt++.
  - After writing address 31, go to IDLE and set cursor=0.
  - A clear takes exactly 32 cycles. in_ready=0 and busy=1 throughout.
- IDLE state: in_ready=1, busy=0. On a transfer, in_char is handled as follows:
  - 0x20-0x7E: mem[cursor] <= in_char; cursor <= cursor+1. Wrap 31 -> 0 is natural 5-bit overflow; writing at 15 moves to 16.
  - 0x0D (CR): cursor <= {cursor[4], 4'b0000}, i.e. start of the current line. No write.
  - 0x0A (LF): cursor <= {~cursor[4], 4'b0000}, i.e. start of the other line; line 1 wraps to line 0. No write, no scroll.
  - 0x08 (BS): cursor <= cursor-1, with 0 wrapping to 31. No write.
  - 0x0C (FF): go to CLEAR with clr_cnt=0.
    - in_ready drops the cycle after the FF transfer.
    - Exactly 32 cycles later in_ready=1 with cursor=0.
  - Any other code: consumed (transfer completes) and ignored. No state change.
- in_ready is a registered function of state and never depends combinationally on in_valid.
- Throughput: one character per cycle in IDLE; in_ready stays high across back-to-back printable characters.
- cursor and busy are registered outputs.

Test Plan:
1. Reset asserted 2 cycles, then released -> busy=1 and in_ready=0 for 32 cycles. Then in_ready=1, cursor=0, and lcd_char=8'h20 for all lcd_index 0..31.
2. Stream "HELLO" (0x48,0x45,0x4C,0x4C,0x4F) with in_valid held high -> 5 transfers in 5 cycles. mem[0..4]=HELLO, cursor=5, lcd_index=4 reads 8'h4F.
3. Write 16 chars 'A' from cursor 0, then 0x0D, then 'B' -> mem[16]=8'h42, cursor=17. Then 0x0A then 'C' -> mem[0]=8'h43, cursor=1.
4. With cursor=31, write 'Z' -> mem[31]=8'h5A, cursor=0. Then 0x08 -> cursor=31.
5. Send 0x0C after writing data -> in_ready low for exactly 32 cycles, all entries read 8'h20, cursor=0. Assert reset at clear cycle 10 -> clear restarts and in_ready is low for 32 cycles after reset release.
6. Send 0x07 and 0xFF with cursor=3 -> both transfers complete, contents unchanged, cursor=3. Write 'Q' at cursor 3 while lcd_index=3 -> lcd_char is the old value in the write cycle and 8'h51 the next cycle.
